mpc_pipe: RTL and testbench
===========================

MPC_PIPE -- requirements
Module: mpc_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 2..32.
REQ-002 Derived constant IW = 3+2*WIDTH: instruction width (19 at default).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 instr  input  IW  instruction {op[2:0], a[WIDTH-1:0], b[WIDTH-1:0]}, with op in the MSBs.
REQ-006 in_valid  input  1  instr is valid this cycle.
REQ-007 in_ready  output  1  block can accept an instruction this cycle.
REQ-008 out  output  2*WIDTH  result, zero-extended unless stated otherwise.
REQ-009 out_valid  output  1  out holds a completed result.
REQ-010 out_ready  input  1  consumer takes out this cycle.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 Op encoding:
- 000 ADD: out = a+b, WIDTH+1 bits, carry in bit WIDTH.
- 001 SUB: out = a-b, WIDTH+1 bits two's complement; bit WIDTH is the borrow.
- 010 AND, 011 OR, 100 XOR: bitwise result, WIDTH bits.
- 101 MUL: unsigned a*b, 2*WIDTH bits.
- 110 SHL: a << b[clog2(WIDTH)-1:0], truncated to WIDTH bits.
- 111 SHR: logical a >> b[clog2(WIDTH)-1:0].
REQ-013 All upper bits of out not defined by the op SHALL be 0.
REQ-014 FSM states: IDLE, MUL, DONE.
REQ-015 Handshake transfer SHALL occur when in_valid && in_ready at a rising edge.
REQ-016 in_ready SHALL be 1 only in IDLE (combinational from state).
REQ-017 IDLE, transfer of a non-MUL op: latch the result into out and go to DONE; out_valid SHALL be 1 in the next cycle (latency 1).
REQ-018 IDLE, transfer of MUL: latch a, b; clear the accumulator and a WIDTH-step counter; go to MUL.
REQ-019 MUL SHALL perform one shift-add step per cycle, LSB of the multiplier first, for exactly WIDTH cycles, then go to DONE; out_valid SHALL rise WIDTH+1 cycles after the transfer edge.
REQ-020 MUL SHALL ignore in_valid; instr may change freely without effect.
REQ-021 DONE: out and out_valid SHALL hold stable until out_ready=1; on that edge go to IDLE and clear out_valid.
REQ-022 out_ready while not in DONE SHALL have no effect.
REQ-023 in_valid=0 in IDLE SHALL keep the block in IDLE with out unchanged.
REQ-024 Maximum throughput SHALL be one non-MUL op per 2 cycles (no accept in the cycle a result is consumed).
REQ-025 out SHALL retain the last result after consumption until the next result is latched.
REQ-026 Shift by 0 SHALL return a; SHL/SHR by WIDTH-1 SHALL leave only a single surviving bit position.
REQ-027 MUL by 0 and MUL of all-ones SHALL each still take WIDTH cycles, with no early exit.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for clk, force:
- state=IDLE, out=0, out_valid=0, busy=0;
- MUL counter and accumulator to 0.
REQ-029 Reset asserted during MUL or DONE SHALL abort the operation; the result is discarded and never presented.
REQ-030 After rst_n rises, in_ready SHALL be 1, and the first edge with in_valid=1 SHALL be accepted.

Verification
REQ-031 WIDTH=8, ADD a=8'hFF, b=8'h01 -> out=16'h0100 and out_valid one cycle after transfer; with out_ready=1, next state IDLE.
REQ-032 WIDTH=8, SUB a=8'h01, b=8'h02 -> out=16'h01FF (borrow=1); AND 8'h4D & 8'h2F -> out=16'h000D.
REQ-033 WIDTH=8, MUL a=8'hFF, b=8'hFF -> busy=1 for 8 cycles, then out=16'hFE01 with out_valid 9 cycles after transfer; in_ready=0 throughout.
REQ-034 Back-pressure: ADD result presented, out_ready=0 for 5 cycles while instr and in_valid change -> out and out_valid stable, no new accept; out_ready=1 -> IDLE.
REQ-035 Reset mid-MUL, 4 steps done, rst_n=0 -> out=0, out_valid=0, busy=0 immediately; after release, SHL a=8'h81, b=8'h03 -> out=16'h0008.
REQ-036 WIDTH=16, MUL 16'hFFFF * 16'h0002 -> out=32'h0001FFFE after 17 cycles; SHR 16'h8000 by 15 -> out=32'h00000001.

Source files
------------

// File: rtl/mpc_pipe_if.sv
// Instruction/result handshake bundle for mpc_pipe.
// The master drives instructions and consumes results; the slave is the execution block.
interface mpc_pipe_if #(
  parameter int WIDTH = 8
);
  localparam int IW = 3 + 2*WIDTH;

  logic [IW-1:0]      instr;
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] out;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  modport master (
    output instr, in_valid, out_ready,
    input  in_ready, out, out_valid, busy
  );

  modport slave (
    input  instr, in_valid, out_ready,
    output in_ready, out, out_valid, busy
  );
endinterface

// File: rtl/mpc_pipe.sv
// Multi-cycle ALU: single-cycle logic/arith ops and a WIDTH-step shift-add multiplier,
// with a valid/ready handshake on both the instruction and result sides.
module mpc_pipe #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  mpc_pipe_if.slave  bus
);
  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic [1:0]         state;
  logic [2:0]         op;
  logic [WIDTH-1:0]   a, b;
  logic [2*WIDTH-1:0] out_q, acc, mcand, step_sum;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               out_valid_q;
  logic               take_mul;

  assign {op, a, b} = bus.instr;

  // Single-cycle ops; every bit above the op's natural width stays zero.
  function automatic logic [2*WIDTH-1:0] alu(input logic [2:0] opc,
                                             input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    logic [2*WIDTH-1:0] r;
    logic [SW-1:0]      sh;
    r  = '0;
    sh = y[SW-1:0];
    case (opc)
      OP_ADD:  r[WIDTH:0]   = {1'b0, x} + {1'b0, y};
      OP_SUB:  r[WIDTH:0]   = {1'b0, x} - {1'b0, y};
      OP_AND:  r[WIDTH-1:0] = x & y;
      OP_OR:   r[WIDTH-1:0] = x | y;
      OP_XOR:  r[WIDTH-1:0] = x ^ y;
      OP_SHL:  r[WIDTH-1:0] = x << sh;
      OP_SHR:  r[WIDTH-1:0] = x >> sh;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign take_mul = (state == S_IDLE) && bus.in_valid && (op == OP_MUL);
  assign step_sum = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (op == OP_MUL) begin
              acc   <= '0;
              cnt   <= '0;
              state <= S_MUL;
            end else begin
              out_q       <= alu(op, a, b);
              out_valid_q <= 1'b1;
              state       <= S_DONE;
            end
          end
        end
        // One partial product per cycle; always WIDTH steps, even for trivial operands.
        S_MUL: begin
          acc <= step_sum;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            out_q       <= step_sum;
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand shift registers need no reset: they are loaded on every MUL accept.
  always_ff @(posedge clk) begin
    if (take_mul) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (state == S_MUL) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_mpc_pipe.sv
// Directed bench for mpc_pipe: one WIDTH=8 and one WIDTH=16 instance on a shared clock/reset.
module tb_mpc_pipe;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mpc_pipe_if #(.WIDTH(8))  b8 ();
  mpc_pipe_if #(.WIDTH(16)) b16 ();

  mpc_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  mpc_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op8(input string tag, input logic [2:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic [15:0] exp);
    b8.instr    = {op, a, b};
    b8.in_valid = 1'b1;
    step();
    b8.in_valid = 1'b0;
    chk({tag, "_vld"},  32'(b8.out_valid), 32'd1);
    chk({tag, "_out"},  32'(b8.out),       32'(exp));
    chk({tag, "_busy"}, 32'(b8.busy),      32'd1);
    b8.out_ready = 1'b1;
    step();
    b8.out_ready = 1'b0;
    chk({tag, "_rdy"},  32'(b8.in_ready),  32'd1);
    chk({tag, "_keep"}, 32'(b8.out),       32'(exp));
  endtask

  task automatic mul8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp);
    b8.instr    = {3'b101, a, b};
    b8.in_valid = 1'b1;
    step();
    for (int k = 1; k <= 8; k++) begin
      chk({tag, "_wait"}, 32'(b8.out_valid), 32'd0);
      chk({tag, "_busy"}, 32'(b8.busy),      32'd1);
      chk({tag, "_nrdy"}, 32'(b8.in_ready),  32'd0);
      b8.instr    = 19'($urandom);
      b8.in_valid = k[0];
      step();
    end
    b8.in_valid = 1'b0;
    chk({tag, "_vld"}, 32'(b8.out_valid), 32'd1);
    chk({tag, "_out"}, 32'(b8.out),       32'(exp));
    b8.out_ready = 1'b1;
    step();
    b8.out_ready = 1'b0;
    chk({tag, "_rdy"}, 32'(b8.in_ready),  32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    b8.instr = '0;  b8.in_valid = 1'b0;  b8.out_ready = 1'b0;
    b16.instr = '0; b16.in_valid = 1'b0; b16.out_ready = 1'b0;
    repeat (2) step();
    chk("rst_out",  32'(b8.out),       32'd0);
    chk("rst_vld",  32'(b8.out_valid), 32'd0);
    chk("rst_busy", 32'(b8.busy),      32'd0);
    rst_n = 1'b1;
    chk("rst_rdy",  32'(b8.in_ready),  32'd1);

    // Single-cycle ops
    op8("add",  3'b000, 8'hFF, 8'h01, 16'h0100);
    op8("sub",  3'b001, 8'h01, 8'h02, 16'h01FF);
    op8("and",  3'b010, 8'h4D, 8'h2F, 16'h000D);
    op8("or",   3'b011, 8'h4D, 8'h2F, 16'h006F);
    op8("xor",  3'b100, 8'h4D, 8'h2F, 16'h0062);
    op8("shl0", 3'b110, 8'hA5, 8'h08, 16'h00A5);
    op8("shl7", 3'b110, 8'hFF, 8'h07, 16'h0080);
    op8("shr7", 3'b111, 8'hFF, 8'h07, 16'h0001);

    // Back-pressure: result held while instr/in_valid wiggle
    b8.instr    = {3'b000, 8'h12, 8'h34};
    b8.in_valid = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      b8.instr    = 19'($urandom);
      b8.in_valid = 1'b1;
      chk("bp_out", 32'(b8.out),       32'h0046);
      chk("bp_vld", 32'(b8.out_valid), 32'd1);
      chk("bp_rdy", 32'(b8.in_ready),  32'd0);
      step();
    end
    b8.instr     = {3'b000, 8'h01, 8'h01};
    b8.out_ready = 1'b1;
    step();
    b8.out_ready = 1'b0;
    chk("cons_vld", 32'(b8.out_valid), 32'd0);
    chk("cons_rdy", 32'(b8.in_ready),  32'd1);
    chk("cons_out", 32'(b8.out),       32'h0046);
    step();
    b8.in_valid = 1'b0;
    chk("next_vld", 32'(b8.out_valid), 32'd1);
    chk("next_out", 32'(b8.out),       32'h0002);
    b8.out_ready = 1'b1;
    step();
    b8.out_ready = 1'b0;

    // Multiplier latency and results
    mul8("mul0",  8'h37, 8'h00, 16'h0000);
    mul8("mulff", 8'hFF, 8'hFF, 16'hFE01);
    mul8("mul",   8'h0D, 8'h0B, 16'h008F);

    // Reset after 4 multiply steps
    b8.instr    = {3'b101, 8'h0F, 8'h0F};
    b8.in_valid = 1'b1;
    step();
    b8.in_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("arst_out",  32'(b8.out),       32'd0);
    chk("arst_vld",  32'(b8.out_valid), 32'd0);
    chk("arst_busy", 32'(b8.busy),      32'd0);
    step();
    rst_n = 1'b1;
    chk("arst_rdy",  32'(b8.in_ready),  32'd1);
    op8("shl3", 3'b110, 8'h81, 8'h03, 16'h0008);

    // WIDTH=16 instance
    b16.instr    = {3'b101, 16'hFFFF, 16'h0002};
    b16.in_valid = 1'b1;
    step();
    b16.in_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      chk("m16_wait", 32'(b16.out_valid), 32'd0);
      step();
    end
    chk("m16_vld", 32'(b16.out_valid), 32'd1);
    chk("m16_out", b16.out,            32'h0001FFFE);
    b16.out_ready = 1'b1;
    step();
    b16.out_ready = 1'b0;
    b16.instr    = {3'b111, 16'h8000, 16'h000F};
    b16.in_valid = 1'b1;
    step();
    b16.in_valid = 1'b0;
    chk("shr16_vld", 32'(b16.out_valid), 32'd1);
    chk("shr16_out", b16.out,            32'h00000001);
    b16.out_ready = 1'b1;
    step();
    b16.out_ready = 1'b0;
    chk("shr16_rdy", 32'(b16.in_ready),  32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
